pc_fetch_unit: RTL
==================

# pc_fetch_unit

Instruction-fetch front end of the MIPS pipeline. Owns the program counter, issues one instruction-memory read at a time over a request/response handshake, and loads the IF/ID pipeline register. It consumes the branch/jump target chosen downstream in EX and produces the PC and instruction consumed by decode. It handles hazard stalls, redirects and variable-latency memory.

## Interface
- `RESET_PC`, 32'h0040_0030: PC value after reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall_i`  in  1  hazard unit: hold IF/ID contents.
- `redirect_i`  in  1  taken branch/jump in EX; flush and retarget.
- `redirect_pc_i`  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- `imem_req_o`  out  1  read request valid.
- `imem_addr_o`  out  32  read address (word aligned).
- `imem_ready_i`  in  1  memory accepts the request this cycle.
- `imem_rvalid_i`  in  1  read data valid, earliest one cycle after acceptance.
- `imem_rdata_i`  in  32  instruction word.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction (0 = bubble).
- `ifid_instr_o`  out  32  fetched instruction.
- `ifid_pc_o`  out  32  address of that instruction.
- `ifid_pc4_o`  out  32  `ifid_pc_o + 4`, with modulo 2^32 wrap.

## Operation
- FSM states are REQ, WAIT and HOLD. Register `pc`, 1-bit `drop`, 32-bit `hold_buf`.
- REQ
  - `imem_req_o=1`, `imem_addr_o=pc`. Both are derived from registered state only.
  - On `imem_ready_i`, go to WAIT.
- WAIT
  - `imem_req_o=0`. Remain until `imem_rvalid_i`.
  - On `imem_rvalid_i` with `drop=1`: discard the data, clear `drop`, go to REQ.
  - On `imem_rvalid_i`, no drop, `!stall_i`: load IF/ID, `pc<=pc+4`, go to REQ.
  - On `imem_rvalid_i`, no drop, `stall_i`: save data in `hold_buf`, go to HOLD.
- HOLD
  - When `!stall_i`: load IF/ID from `hold_buf`, `pc<=pc+4`, go to REQ.
- Redirect has highest priority in every state.
  - `pc<=redirect_pc_i & ~3`. `ifid_valid_o<=0` next cycle, even if `stall_i` is asserted.
  - In REQ: if `imem_ready_i` is also asserted, the accepted old-address read goes to WAIT with `drop=1`. Otherwise stay in REQ with the new address.
  - In WAIT: set `drop=1`. If `imem_rvalid_i` is also asserted, discard the data and go to REQ.
  - In HOLD: discard `hold_buf`, go to REQ.
- IF/ID update
  - Stall without redirect: all IF/ID outputs hold.
  - No stall, no new instruction: `ifid_valid_o<=0`. Other IF/ID fields hold.
- PC arithmetic is 32-bit unsigned with wrap: 0xFFFF_FFFC + 4 = 0.
- Reset applies at any point, mid-transaction included. Any in-flight response arriving after reset release in REQ is ignored, because `imem_rvalid_i` is only sampled in WAIT.

## Timing
- Reset values:
  - state = REQ, `pc = RESET_PC`, `drop = 0`.
  - `imem_req_o = 1`, `imem_addr_o = RESET_PC` in the first cycle after reset release.
  - `ifid_valid_o = 0`; `ifid_instr_o`, `ifid_pc_o`, `ifid_pc4_o` = 0.
- Best case (memory accepts at cycle n, rvalid at n+1):
  - IF/ID is valid at n+2.
  - Next request issues at n+2.
  - Throughput is one instruction per 2 cycles.
- Redirect asserted at cycle n:
  - `ifid_valid_o=0` at n+1.
  - The request to the target is no earlier than n+1, or after the outstanding dropped response returns.
- At most one outstanding request at all times.

## Structure
- Shared package `cpu_pkg`: `RESET_PC_DEFAULT = 32'h0040_0030`, `fetch_state_t` enum {REQ, WAIT, HOLD}, `INSTR_W = 32`.
- One sub-module, `ifid_reg`: IF/ID register with load, hold and bubble (valid-clear) controls. The FSM and PC stay in `pc_fetch_unit`.

## Test plan
- Reset, then single-cycle-ready memory returning 0x2008_0005 at 0x0040_0030 → `imem_addr_o=0x0040_0030` on the first cycle; IF/ID valid with pc 0x0040_0030 and pc4 0x0040_0034 two cycles after acceptance; next address 0x0040_0034.
- `stall_i` held 3 cycles, starting as rvalid arrives → FSM in HOLD; IF/ID unchanged; buffered word loaded on the cycle `stall_i` drops; no extra memory request meanwhile.
- Redirect to 0x0040_0103 during WAIT → in-flight response discarded; `ifid_valid_o=0` next cycle; next request address 0x0040_0100.
- Redirect in the same cycle as `imem_ready_i`, plus a redirect coinciding with `stall_i` → old-address data is never loaded; bubble inserted despite stall; fetch resumes at the target.
- `pc`=0xFFFF_FFFC fetch → `ifid_pc4_o=0x0000_0000`, next request address 0.
- Reset asserted in WAIT with a late rvalid → outputs return to reset values; first request is `RESET_PC`; the stale rvalid is not loaded.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch front end
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0030;
  localparam int          INSTR_W          = 32;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module ifid_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic               hold,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [31:0]        next_pc,
  input  logic [31:0]        next_pc4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc,
  output logic [31:0]        pc4
);

  // Flush beats hold: a redirect must bubble decode even while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= next_instr;
      pc    <= next_pc;
      pc4   <= next_pc4;
    end else if (!hold) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch FSM: owns the PC, one outstanding imem read,
// feeds the IF/ID register
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               ifid_valid_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [31:0]        ifid_pc_o,
  output logic [31:0]        ifid_pc4_o
);

  fetch_state_t       state;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic               drop;
  logic [INSTR_W-1:0] hold_buf;
  logic               ifid_load;
  logic [INSTR_W-1:0] ifid_next_instr;

  assign pc_plus4    = pc + 32'd4;
  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = pc;

  assign ifid_load = !redirect_i && !stall_i &&
                     ((state == WAIT && imem_rvalid_i && !drop) || state == HOLD);
  assign ifid_next_instr = (state == HOLD) ? hold_buf : imem_rdata_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      hold_buf <= '0;
    end else if (redirect_i) begin
      pc <= redirect_pc_i & ~32'd3;
      case (state)
        REQ: begin
          // An accepted read to the old address still owes us a response.
          if (imem_ready_i) begin
            state <= WAIT;
            drop  <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state <= REQ;
            drop  <= 1'b0;
          end else begin
            drop <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem_ready_i) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else if (!stall_i) begin
              pc    <= pc_plus4;
              state <= REQ;
            end else begin
              hold_buf <= imem_rdata_i;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            pc    <= pc_plus4;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_i),
    .load       (ifid_load),
    .hold       (stall_i),
    .next_instr (ifid_next_instr),
    .next_pc    (pc),
    .next_pc4   (pc_plus4),
    .valid      (ifid_valid_o),
    .instr      (ifid_instr_o),
    .pc         (ifid_pc_o),
    .pc4        (ifid_pc4_o)
  );

endmodule
